// File: rtl/limber_gnrl_pkg.sv
// Shared definitions for the Limber general-logic blocks: state encoding
// for the pulse stretcher and its default counter width.
package limber_gnrl_pkg;

  localparam int DEFAULT_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } stretch_state_e;

  function automatic logic isBusy(input stretch_state_e state);
    return state != IDLE;
  endfunction

endpackage

// File: rtl/limber_gnrl_stretch.sv
// Pulse-to-level stretcher: a one-cycle trigger produces a clean level of
// programmable width, followed by an optional low hold-off gap.
module limber_gnrl_stretch
  import limber_gnrl_pkg::*;
#(
  parameter int CNT_W  = DEFAULT_CNT_W,
  parameter bit RETRIG = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pulse,
  input  logic [CNT_W-1:0] i_width,
  input  logic [CNT_W-1:0] i_gap,
  output logic             o_level,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_drop
);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  stretch_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic             level_q, level_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;

  // One down-counter serves both phases; its meaning depends on the state.
  // Width and gap are captured only on an accepted trigger so that later
  // input changes cannot disturb the operation in progress.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_pulse) begin
          if (i_width != CNT_ZERO) begin
            width_d = i_width;
            gap_d   = i_gap;
            cnt_d   = i_width - CNT_ONE;
            state_d = HIGH;
          end else begin
            drop_d = 1'b1;
          end
        end
      end

      HIGH: begin
        if (i_pulse && RETRIG) begin
          cnt_d = width_q - CNT_ONE;
        end else begin
          drop_d = i_pulse;
          if (cnt_q == CNT_ZERO) begin
            done_d = 1'b1;
            if (gap_q == CNT_ZERO) begin
              state_d = IDLE;
            end else begin
              cnt_d   = gap_q - CNT_ONE;
              state_d = GAP;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end

      GAP: begin
        drop_d = i_pulse;
        if (cnt_q == CNT_ZERO) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    level_d = (state_d == HIGH);
    busy_d  = isBusy(state_d);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      width_q <= CNT_ZERO;
      gap_q   <= CNT_ZERO;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      width_q <= width_d;
      gap_q   <= gap_d;
      level_q <= level_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign o_level = level_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_drop  = drop_q;

endmodule

// File: tb/tb_limber_gnrl_stretch.sv
// Directed bench for limber_gnrl_stretch: one instance without retrigger
// (suffix A) and one with retrigger (suffix R) share all inputs.
module tb_limber_gnrl_stretch;

  logic       clk;
  logic       rstN;
  logic       pulse;
  logic [7:0] width;
  logic [7:0] gap;

  logic levelA, busyA, doneA, dropA;
  logic levelR, busyR, doneR, dropR;

  int testsRun;
  int testsFailed;

  limber_gnrl_stretch #(.CNT_W(8), .RETRIG(1'b0)) dutA (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .i_pulse (pulse),
    .i_width (width),
    .i_gap   (gap),
    .o_level (levelA),
    .o_busy  (busyA),
    .o_done  (doneA),
    .o_drop  (dropA)
  );

  limber_gnrl_stretch #(.CNT_W(8), .RETRIG(1'b1)) dutR (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .i_pulse (pulse),
    .i_width (width),
    .i_gap   (gap),
    .o_level (levelR),
    .o_busy  (busyR),
    .o_done  (doneR),
    .o_drop  (dropR)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present the trigger for one rising edge and leave the bench 1 time unit
  // after that edge, so the outputs read next reflect that edge.
  task automatic applyStimulus(input logic p);
    pulse = p;
    @(posedge clk);
    #1;
    pulse = 1'b0;
  endtask

  task automatic test_reset();
    rstN  = 1'b0;
    pulse = 1'b0;
    width = 8'd0;
    gap   = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    testsRun++;
    if ({levelA, busyA, doneA, dropA} !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL reset A: got %b expected 0000", {levelA, busyA, doneA, dropA});
    end
    testsRun++;
    if ({levelR, busyR, doneR, dropR} !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL reset R: got %b expected 0000", {levelR, busyR, doneR, dropR});
    end
    rstN = 1'b1;
    applyStimulus(1'b0);
  endtask

  task automatic test_basic();
    logic [31:0] pMask, lMask, dMask, xMask, bMask;
    pMask = 32'h1; lMask = 32'h1F; dMask = 32'h20; xMask = 32'h0; bMask = 32'h1F;
    width = 8'd5;
    gap   = 8'd0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(pMask[i]);
      testsRun++;
      if ({levelA, doneA, dropA, busyA} !== {lMask[i], dMask[i], xMask[i], bMask[i]}) begin
        testsFailed++;
        $display("[TB] FAIL basic A edge %0d: got ldxb=%b expected %b", i,
                 {levelA, doneA, dropA, busyA}, {lMask[i], dMask[i], xMask[i], bMask[i]});
      end
      testsRun++;
      if ({levelR, doneR, dropR, busyR} !== {lMask[i], dMask[i], xMask[i], bMask[i]}) begin
        testsFailed++;
        $display("[TB] FAIL basic R edge %0d: got ldxb=%b expected %b", i,
                 {levelR, doneR, dropR, busyR}, {lMask[i], dMask[i], xMask[i], bMask[i]});
      end
    end
  endtask

  task automatic test_gap_drop();
    logic [31:0] pMask, lMask, dMask, xMask, bMask;
    pMask = 32'h1A1; lMask = 32'h707; dMask = 32'h808; xMask = 32'hA0; bMask = 32'h7F7F;
    width = 8'd3;
    gap   = 8'd4;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(pMask[i]);
      testsRun++;
      if ({levelA, doneA, dropA, busyA} !== {lMask[i], dMask[i], xMask[i], bMask[i]}) begin
        testsFailed++;
        $display("[TB] FAIL gap A edge %0d: got ldxb=%b expected %b", i,
                 {levelA, doneA, dropA, busyA}, {lMask[i], dMask[i], xMask[i], bMask[i]});
      end
      testsRun++;
      if ({levelR, doneR, dropR, busyR} !== {lMask[i], dMask[i], xMask[i], bMask[i]}) begin
        testsFailed++;
        $display("[TB] FAIL gap R edge %0d: got ldxb=%b expected %b", i,
                 {levelR, doneR, dropR, busyR}, {lMask[i], dMask[i], xMask[i], bMask[i]});
      end
    end
  endtask

  task automatic test_retrigger();
    logic [31:0] pMask, lA, dA, xA, bA, lR, dR, xR, bR;
    width = 8'd4;
    gap   = 8'd0;
    for (int run = 0; run < 2; run++) begin
      if (run == 0) begin
        pMask = 32'h5;  lA = 32'hF; dA = 32'h10; xA = 32'h4;  bA = 32'hF;
        lR = 32'h3F; dR = 32'h40;  xR = 32'h0; bR = 32'h3F;
      end else begin
        pMask = 32'h11; lA = 32'hF; dA = 32'h10; xA = 32'h10; bA = 32'hF;
        lR = 32'hFF; dR = 32'h100; xR = 32'h0; bR = 32'hFF;
      end
      for (int i = 0; i < 10; i++) begin
        applyStimulus(pMask[i]);
        testsRun++;
        if ({levelA, doneA, dropA, busyA} !== {lA[i], dA[i], xA[i], bA[i]}) begin
          testsFailed++;
          $display("[TB] FAIL retrig%0d A edge %0d: got ldxb=%b expected %b", run, i,
                   {levelA, doneA, dropA, busyA}, {lA[i], dA[i], xA[i], bA[i]});
        end
        testsRun++;
        if ({levelR, doneR, dropR, busyR} !== {lR[i], dR[i], xR[i], bR[i]}) begin
          testsFailed++;
          $display("[TB] FAIL retrig%0d R edge %0d: got ldxb=%b expected %b", run, i,
                   {levelR, doneR, dropR, busyR}, {lR[i], dR[i], xR[i], bR[i]});
        end
      end
    end
  endtask

  task automatic test_zero_width();
    logic [31:0] pMask, xMask;
    pMask = 32'h1; xMask = 32'h1;
    width = 8'd0;
    gap   = 8'd3;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(pMask[i]);
      testsRun++;
      if ({levelA, doneA, dropA, busyA} !== {1'b0, 1'b0, xMask[i], 1'b0}) begin
        testsFailed++;
        $display("[TB] FAIL zero A edge %0d: got ldxb=%b expected %b", i,
                 {levelA, doneA, dropA, busyA}, {1'b0, 1'b0, xMask[i], 1'b0});
      end
      testsRun++;
      if ({levelR, doneR, dropR, busyR} !== {1'b0, 1'b0, xMask[i], 1'b0}) begin
        testsFailed++;
        $display("[TB] FAIL zero R edge %0d: got ldxb=%b expected %b", i,
                 {levelR, doneR, dropR, busyR}, {1'b0, 1'b0, xMask[i], 1'b0});
      end
    end
  endtask

  task automatic test_width_change();
    logic [31:0] pMask, lMask, dMask, bMask;
    pMask = 32'h1; lMask = 32'h7; dMask = 32'h8; bMask = 32'h7;
    width = 8'd3;
    gap   = 8'd0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(pMask[i]);
      width = 8'd2;
      gap   = 8'd5;
      testsRun++;
      if ({levelA, doneA, dropA, busyA} !== {lMask[i], dMask[i], 1'b0, bMask[i]}) begin
        testsFailed++;
        $display("[TB] FAIL wchange A edge %0d: got ldxb=%b expected %b", i,
                 {levelA, doneA, dropA, busyA}, {lMask[i], dMask[i], 1'b0, bMask[i]});
      end
    end
  endtask

  task automatic test_max_width();
    int highCount;
    int doneIdx;
    highCount = 0;
    doneIdx   = -1;
    width = 8'd255;
    gap   = 8'd0;
    for (int i = 0; i < 260; i++) begin
      applyStimulus(i == 0);
      if (levelA) highCount++;
      if (doneA && doneIdx < 0) doneIdx = i;
    end
    testsRun++;
    if (highCount !== 255) begin
      testsFailed++;
      $display("[TB] FAIL maxwidth high cycles: got %0d expected 255", highCount);
    end
    testsRun++;
    if (doneIdx !== 255) begin
      testsFailed++;
      $display("[TB] FAIL maxwidth done edge: got %0d expected 255", doneIdx);
    end
    testsRun++;
    if (busyA !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL maxwidth busy after: got %b expected 0", busyA);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] lMask, dMask, bMask;
    width = 8'd10;
    gap   = 8'd0;
    applyStimulus(1'b1);
    repeat (3) applyStimulus(1'b0);
    testsRun++;
    if (levelA !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL areset pre level: got %b expected 1", levelA);
    end
    #2;
    rstN = 1'b0;
    #1;
    testsRun++;
    if ({levelA, busyA, doneA, dropA, levelR, busyR} !== 6'b000000) begin
      testsFailed++;
      $display("[TB] FAIL areset immediate: got %b expected 000000",
               {levelA, busyA, doneA, dropA, levelR, busyR});
    end
    @(posedge clk);
    #1;
    testsRun++;
    if ({doneA, doneR, levelA} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL areset no done: got %b expected 000", {doneA, doneR, levelA});
    end
    rstN = 1'b1;
    applyStimulus(1'b0);
    lMask = 32'h3; dMask = 32'h4; bMask = 32'h3;
    width = 8'd2;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i == 0);
      testsRun++;
      if ({levelA, doneA, dropA, busyA} !== {lMask[i], dMask[i], 1'b0, bMask[i]}) begin
        testsFailed++;
        $display("[TB] FAIL areset after A edge %0d: got ldxb=%b expected %b", i,
                 {levelA, doneA, dropA, busyA}, {lMask[i], dMask[i], 1'b0, bMask[i]});
      end
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    test_reset();
    test_basic();
    test_gap_drop();
    test_retrigger();
    test_zero_width();
    test_width_change();
    test_max_width();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/limber_gnrl_stretch.md
Name: limber_gnrl_stretch

Overview:
- Pulse-to-level stretcher, the inverse of a rising-edge detector: accepts a single-cycle trigger pulse and drives a clean output level for a programmable number of cycles.
- Adds an optional retrigger mode and a programmable hold-off gap.
- Reports completion and dropped triggers.
- Used in Limber IoT NP general logic for LED/strobe drive, peripheral enable windows and minimum-width timing of control signals.

Parameters:
- CNT_W, 8: width of the width/gap counters; maximum programmable value is 2^CNT_W-1.
- RETRIG, 0: 1 = a trigger during HIGH reloads the width counter; 0 = such a trigger is dropped.

Ports:
- i_clk  input  1  system clock; all logic on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_pulse  input  1  trigger; sampled every clock edge, normally one cycle wide.
- i_width  input  CNT_W  output high time in cycles; sampled only on an accepted trigger.
- i_gap  input  CNT_W  low hold-off after the level falls; sampled at the same time as i_width.
- o_level  output  1  stretched level, registered.
- o_busy  output  1  high while the state is not IDLE, registered.
- o_done  output  1  one-cycle pulse in the first cycle after o_level falls, registered.
- o_drop  output  1  one-cycle pulse, one cycle after a trigger that was ignored, registered.

Behaviour:
- Reset (async assert, sync release): state=IDLE, counters=0, latched width/gap=0; o_level=0, o_busy=0, o_done=0, o_drop=0. Reset mid-operation aborts immediately and no o_done is issued.
- States:
  - IDLE: output low, accepts triggers.
  - HIGH: o_level=1, width counter running.
  - GAP: o_level=0, gap counter running, triggers rejected.
- IDLE, i_pulse=1, i_width!=0: latch i_width and i_gap, load width counter with i_width-1, go to HIGH. o_level rises on the next edge (latency 1).
- IDLE, i_pulse=1, i_width=0: stay in IDLE, assert o_drop for 1 cycle. No level, no o_done.
- HIGH: decrement each cycle. When the counter is 0:
  - latched gap=0: go to IDLE.
  - otherwise: load gap counter with gap-1 and go to GAP.
  - Either way, o_level falls and o_done=1 for exactly one cycle.
- Resulting timing for a trigger sampled at edge t: o_level=1 for cycles t+1..t+W (exactly W cycles); o_done=1 in cycle t+W+1.
- HIGH, i_pulse=1:
  - RETRIG=1: reload the width counter with latched width-1. o_level stays high for W cycles after the retrigger edge, with no glitch. Retrigger on the final HIGH cycle also extends the level and suppresses o_done.
  - RETRIG=0: ignore the trigger, o_drop=1.
- GAP: decrement each cycle; at 0 go to IDLE. The low time is exactly G cycles, during which any i_pulse gives o_drop. A trigger on the edge that enters IDLE is dropped; the first acceptable trigger is in the following cycle.
- Changes on i_width/i_gap outside an accepted trigger have no effect on the operation in progress.
- o_done and o_drop may be high in the same cycle (trigger during the first GAP cycle, or an ignored trigger at the falling edge).
- No arithmetic wrap: counters never decrement below 0. Widths up to 2^CNT_W-1 are supported exactly.

Decomposition:
- Shared package: limber_gnrl_pkg holds the state encoding constants (IDLE=2'd0, HIGH=2'd1, GAP=2'd2) and a default CNT_W constant.
- Single module; no sub-module is needed. The width and gap counters share one down-counter register, selected by state.

Test Plan:
- Reset and basic timing: hold i_rst_n=0, then release. Pulse at edge 10, W=5, G=0 -> o_level high cycles 11-15; o_done=1 at cycle 16; o_busy low from cycle 16.
- Gap and drop: W=3, G=4, pulse at edge 10 and again at edge 15 -> o_level cycles 11-13; second pulse gives o_drop at 16; a pulse at edge 18 is accepted (level 19-21).
- Retrigger: RETRIG=1, W=4, pulses at edges 10 and 12 -> o_level continuous 11-16, a single o_done at 17. With RETRIG=0, same stimulus -> level 11-14 and o_drop at 13.
- Zero width and max width:
  - i_width=0 pulse -> o_drop only, o_level stays 0.
  - i_width=255 (CNT_W=8) -> exactly 255 high cycles.
  - i_width changed to 2 mid-HIGH -> no effect.
- Async reset mid-HIGH: W=10, assert i_rst_n=0 at cycle 14, off-edge -> o_level, o_busy 0 immediately; no o_done. A new pulse after release behaves normally.
